workmem_arbiter: RTL and testbench
==================================

WORKMEM_ARBITER -- requirements
Module: workmem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters (CPU core = 0, loader/debug port = 1).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning work-memory address width (256 cells).
REQ-003 SHALL have parameter DATA_W, default 6, meaning work-memory word width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester access request, level.
REQ-007 SHALL have port we  input  NREQ  per-requester write (1) / read (0) select.
REQ-008 SHALL have port addr  input  NREQ*ADDR_W  per-requester address, requester i at slice i.
REQ-009 SHALL have port wdata  input  NREQ*DATA_W  per-requester write data.
REQ-010 SHALL have port lock  input  NREQ  per-requester bus-lock request.
REQ-011 SHALL have port gnt  output  NREQ  one-cycle grant pulse, one-hot or zero.
REQ-012 SHALL have port rvalid  output  NREQ  one-cycle read-data-valid pulse.
REQ-013 SHALL have port rdata  output  DATA_W  read data, shared by all requesters.
REQ-014 SHALL have ports mem_en, mem_we (1), mem_addr (ADDR_W), mem_wdata (DATA_W) as outputs, and mem_rdata (DATA_W) as an input, to a synchronous single-port RAM with 1-cycle read latency.

Function
REQ-015 SHALL implement FSM IDLE, ISSUE, RESP.
REQ-016 IDLE: if any req bit is set, SHALL pick a winner round-robin, starting at pointer ptr, latch its we/addr/wdata, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-017 ISSUE: SHALL drive mem_en=1 with the latched mem_we/mem_addr/mem_wdata and gnt[winner]=1 for exactly this cycle, and SHALL set ptr to (winner+1) mod NREQ; a write SHALL go to IDLE and a read SHALL go to RESP.
REQ-018 RESP: SHALL drive rvalid[winner]=1 with rdata=mem_rdata for exactly this cycle, then go to IDLE.
REQ-019 Latency SHALL be req sampled in IDLE -> gnt 1 cycle later -> rvalid 2 cycles later; write throughput 1 per 2 cycles, read throughput 1 per 3 cycles.
REQ-020 A requester SHALL hold req/we/addr/wdata until it sees gnt; changes after the IDLE sample SHALL NOT affect the issued access.
REQ-021 A single active requester SHALL win regardless of ptr.
REQ-022 A req still high in the IDLE following its grant SHALL be treated as a new request.
REQ-023 mem_en, gnt and rvalid SHALL be 0 in every state not named above; rdata SHALL hold its last value outside RESP.
REQ-024 ptr SHALL wrap from NREQ-1 to 0.

Reset
REQ-025 On rst, next state SHALL be IDLE, with ptr=0, gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and rdata=0.
REQ-026 rst during ISSUE or RESP SHALL abort the access: no rvalid is issued, and a write already issued in ISSUE stands.

Configuration
REQ-027 With WORKMEM_ARB_LOCK_EN defined, if the last-granted requester has lock set in IDLE, only that requester SHALL be eligible and ptr SHALL NOT advance; the other requests SHALL wait until lock drops.
REQ-028 Without WORKMEM_ARB_LOCK_EN, the lock port SHALL exist but be ignored, giving pure round-robin.

Structure
REQ-029 Package waterbear_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state enum {IDLE, ISSUE, RESP}.
REQ-030 SHALL instantiate one sub-module, rr_pick, which is a combinational round-robin picker (req, ptr -> one-hot winner, valid).

Verification
REQ-031 After reset, req=01, we=1, addr0=0x0D, wdata0=5: SHALL produce gnt=01 with mem_we=1, mem_addr=0x0D, mem_wdata=5 one cycle later, and rvalid SHALL stay 0.
REQ-032 With RAM[0x0E]=7, req=10, we=0, addr1=0x0E: SHALL produce gnt=10 at cycle+1 and rvalid=10 with rdata=7 at cycle+2.
REQ-033 With req=11 held continuously for four grants from reset: gnt SHALL alternate 01, 10, 01, 10.
REQ-034 With lock0=1 and req=11 held, with macro defined: SHALL grant 01 repeatedly; after lock0 drops, the next grant SHALL be 10. Without the macro: grants SHALL alternate.
REQ-035 Read issued, then rst asserted in RESP: rvalid SHALL stay 0, state SHALL return to IDLE, and the next req=10 SHALL be granted ptr-fairly from ptr=0.

Source files
------------

// File: rtl/waterbear_pkg.sv
// rtl/waterbear_pkg.sv - shared defaults and FSM state type for the work-memory arbiter
package waterbear_pkg;

   localparam int NREQ_DEF   = 2;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 6;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } arb_state_t;

   // Pointer width stays at least one bit so a single-requester build still elaborates.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/workmem_arbiter_if.sv
// rtl/workmem_arbiter_if.sv - requester-side and RAM-side bus of the work-memory arbiter
interface workmem_arbiter_if
   import waterbear_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [NREQ-1:0]        req;
   logic [NREQ-1:0]        we;
   logic [NREQ*ADDR_W-1:0] addr;
   logic [NREQ*DATA_W-1:0] wdata;
   logic [NREQ-1:0]        lock;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        rvalid;
   logic [DATA_W-1:0]      rdata;

   logic                   mem_en;
   logic                   mem_we;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic [DATA_W-1:0]      mem_rdata;

   modport slave (
      input  req, we, addr, wdata, lock, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, addr, wdata, lock, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/workmem_arbiter_rr_pick.sv
// rtl/workmem_arbiter_rr_pick.sv - combinational round-robin picker, first set bit at or after ptr
module rr_pick
   import waterbear_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int PTR_W = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  winner,
   output logic             valid
);

   logic             found;
   logic [PTR_W-1:0] idx;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            winner[idx] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/workmem_arbiter.sv
// rtl/workmem_arbiter.sv - round-robin arbiter onto a 1-cycle-latency single-port work RAM
// Define WORKMEM_ARB_LOCK_EN to let the last-granted requester keep the bus while it holds lock.
module workmem_arbiter
   import waterbear_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input logic              clk,
   input logic              rst,
   workmem_arbiter_if.slave bus
);

   localparam int               PTR_W    = ptr_width(NREQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   arb_state_t        state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [NREQ-1:0]   win_q, win_d;
   logic [PTR_W-1:0]  win_idx_q, win_idx_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [PTR_W-1:0]  last_q, last_d;
   logic              last_v_q, last_v_d;

   logic [NREQ-1:0]   eligible;
   logic [NREQ-1:0]   pick;
   logic              pick_v;
   logic [PTR_W-1:0]  pick_idx;

`ifdef WORKMEM_ARB_LOCK_EN
   // A locked owner masks everyone else; if it is not requesting, nobody wins.
   always_comb begin
      eligible = bus.req;
      if (last_v_q && bus.lock[last_q]) begin
         eligible         = '0;
         eligible[last_q] = bus.req[last_q];
      end
   end
`else
   logic unused_lock;
   assign unused_lock = ^{bus.lock, last_q, last_v_q};
   assign eligible    = bus.req;
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req    (eligible),
      .ptr    (ptr_q),
      .winner (pick),
      .valid  (pick_v)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) pick_idx = PTR_W'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      win_idx_d   = win_idx_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      last_d      = last_q;
      last_v_d    = last_v_q;
      case (state_q)
         IDLE: begin
            if (pick_v) begin
               win_d       = pick;
               win_idx_d   = pick_idx;
               mem_we_d    = bus.we[pick_idx];
               mem_addr_d  = bus.addr[pick_idx*ADDR_W +: ADDR_W];
               mem_wdata_d = bus.wdata[pick_idx*DATA_W +: DATA_W];
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            // Under lock the owner is already ptr-1, so this leaves ptr where it was.
            ptr_d    = (win_idx_q == LAST_IDX) ? '0 : win_idx_q + 1'b1;
            last_d   = win_idx_q;
            last_v_d = 1'b1;
            state_d  = mem_we_q ? IDLE : RESP;
         end
         RESP: begin
            rdata_d = bus.mem_rdata;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // rvalid is gated by rst so a reset landing in RESP aborts the response.
   always_comb begin
      bus.gnt    = '0;
      bus.rvalid = '0;
      bus.mem_en = 1'b0;
      bus.rdata  = rdata_q;
      case (state_q)
         ISSUE: begin
            bus.mem_en = 1'b1;
            bus.gnt    = win_q;
         end
         RESP: begin
            if (!rst) begin
               bus.rvalid = win_q;
               bus.rdata  = bus.mem_rdata;
            end
         end
         default: ;
      endcase
   end

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         win_idx_q   <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         last_q      <= '0;
         last_v_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         win_idx_q   <= win_idx_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         last_q      <= last_d;
         last_v_q    <= last_v_d;
      end
   end

endmodule

// File: tb/tb_workmem_arbiter.sv
// tb/tb_workmem_arbiter.sv - directed self-checking bench for workmem_arbiter
module tb_workmem_arbiter;

   localparam int NREQ   = 2;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 6;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   logic [DATA_W-1:0] ram [0:255];
   logic [DATA_W-1:0] ram_q;
   logic [1:0]        alt_exp [4];
   logic [1:0]        lock_exp [3];

   always #5 clk = ~clk;

   workmem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   workmem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            ram_q <= ram[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = ram_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [5:0] d0, input logic [5:0] d1);
      bus.req   = r;
      bus.we    = w;
      bus.lock  = l;
      bus.addr  = {a1, a0};
      bus.wdata = {d1, d0};
   endtask

   task automatic do_reset();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;
`ifdef WORKMEM_ARB_LOCK_EN
      lock_exp[0] = 2'b01; lock_exp[1] = 2'b01; lock_exp[2] = 2'b01;
`else
      lock_exp[0] = 2'b01; lock_exp[1] = 2'b10; lock_exp[2] = 2'b01;
`endif
      rst = 1'b1;
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      tick();
      tick();
      chk("rst_gnt", bus.gnt, 16'h0);
      chk("rst_rvalid", bus.rvalid, 16'h0);
      chk("rst_mem_en", bus.mem_en, 16'h0);
      chk("rst_mem_we", bus.mem_we, 16'h0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
      chk("rst_rdata", bus.rdata, 16'h0);
      rst = 1'b0;

      // Write 0x0D=5 from requester 0; inputs change after the sample and must not leak through.
      drive(2'b01, 2'b01, 2'b00, 8'h0D, 8'h00, 6'd5, 6'd0);
      tick();
      drive(2'b00, 2'b01, 2'b00, 8'h55, 8'h00, 6'h3F, 6'd0);
      chk("wr_gnt", bus.gnt, 16'h1);
      chk("wr_mem_en", bus.mem_en, 16'h1);
      chk("wr_mem_we", bus.mem_we, 16'h1);
      chk("wr_mem_addr", bus.mem_addr, 16'h0D);
      chk("wr_mem_wdata", bus.mem_wdata, 16'h05);
      chk("wr_rvalid", bus.rvalid, 16'h0);
      tick();
      chk("wr_done_gnt", bus.gnt, 16'h0);
      chk("wr_done_rvalid", bus.rvalid, 16'h0);
      chk("wr_done_mem_en", bus.mem_en, 16'h0);

      // Write 0x0E=7 from requester 1, then read it back.
      drive(2'b10, 2'b10, 2'b00, 8'h00, 8'h0E, 6'd0, 6'd7);
      tick();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      chk("wr1_gnt", bus.gnt, 16'h2);
      tick();
      drive(2'b10, 2'b00, 2'b00, 8'h00, 8'h0E, 6'd0, 6'd0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      chk("rd1_gnt", bus.gnt, 16'h2);
      chk("rd1_mem_we", bus.mem_we, 16'h0);
      chk("rd1_mem_addr", bus.mem_addr, 16'h0E);
      chk("rd1_rvalid_early", bus.rvalid, 16'h0);
      tick();
      chk("rd1_rvalid", bus.rvalid, 16'h2);
      chk("rd1_rdata", bus.rdata, 16'h7);
      chk("rd1_gnt_off", bus.gnt, 16'h0);
      tick();
      chk("rd1_rvalid_off", bus.rvalid, 16'h0);
      chk("rd1_rdata_hold", bus.rdata, 16'h7);

      // Read 0x0D back through requester 0.
      drive(2'b01, 2'b00, 2'b00, 8'h0D, 8'h00, 6'd0, 6'd0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      chk("rd0_gnt", bus.gnt, 16'h1);
      tick();
      chk("rd0_rvalid", bus.rvalid, 16'h1);
      chk("rd0_rdata", bus.rdata, 16'h5);
      tick();

      // Both requesting continuously: strict alternation from ptr=0.
      do_reset();
      drive(2'b11, 2'b11, 2'b00, 8'h20, 8'h21, 6'd1, 6'd2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("alt_gnt%0d", i), bus.gnt, 16'(alt_exp[i]));
         tick();
      end

      // Requester 0 holds lock; release it after the third grant.
      do_reset();
      drive(2'b11, 2'b11, 2'b01, 8'h20, 8'h21, 6'd1, 6'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lock_gnt%0d", i), bus.gnt, 16'(lock_exp[i]));
         if (i == 2) drive(2'b11, 2'b11, 2'b00, 8'h20, 8'h21, 6'd1, 6'd2);
         tick();
      end
      tick();
      chk("unlock_gnt", bus.gnt, 16'h2);

      // Reset landing in RESP aborts the read and restores ptr=0.
      do_reset();
      drive(2'b01, 2'b00, 2'b00, 8'h0D, 8'h00, 6'd0, 6'd0);
      tick();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      chk("abort_gnt", bus.gnt, 16'h1);
      tick();
      rst = 1'b1;
      #1;
      chk("abort_rvalid_resp", bus.rvalid, 16'h0);
      tick();
      rst = 1'b0;
      chk("abort_rvalid_after", bus.rvalid, 16'h0);
      chk("abort_gnt_after", bus.gnt, 16'h0);
      chk("abort_rdata", bus.rdata, 16'h0);
      drive(2'b11, 2'b11, 2'b00, 8'h30, 8'h31, 6'd3, 6'd4);
      tick();
      chk("post_rst_ptr0_gnt", bus.gnt, 16'h1);
      drive(2'b10, 2'b11, 2'b00, 8'h30, 8'h31, 6'd3, 6'd4);
      tick();
      tick();
      chk("post_rst_req1_gnt", bus.gnt, 16'h2);
      chk("post_rst_rvalid", bus.rvalid, 16'h0);
      drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 6'd0, 6'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
